// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: ALU opcodes and FSM states.
package alu_issue_pkg;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } seqState;

endpackage

// File: rtl/alu_issue_rf.sv
// NREG x DATA_W register file: two async read ports, writeback and host write ports.
// When both writes target the same entry, the writeback port wins.
module alu_issue_rf
    import alu_issue_pkg::*;
#(
    parameter  int NREG   = 4,
    parameter  int DATA_W = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     raddrA,
    output logic [DATA_W-1:0] rdataA,
    input  logic [AW-1:0]     raddrB,
    output logic [DATA_W-1:0] rdataB,
    input  logic              wbWe,
    input  logic [AW-1:0]     wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              hostWe,
    input  logic [AW-1:0]     hostAddr,
    input  logic [DATA_W-1:0] hostData
);

    logic [DATA_W-1:0] rf [NREG];

    assign rdataA = rf[raddrA];
    assign rdataB = rf[raddrB];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wbWe && (wbAddr == AW'(i))) begin
                    rf[i] <= wbData;
                end else if (hostWe && (hostAddr == AW'(i))) begin
                    rf[i] <= hostData;
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer for the 4-bit ALU: IDLE -> EXEC -> WB, one command per 3 cycles.
// Optional feature macro ALU_ISSUE_CNT_EN adds a saturating retired-command counter (cmd_count).
module alu_issue_seq
    import alu_issue_pkg::*;
#(
    parameter  int NREG   = 4,
    parameter  int DATA_W = 4,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_shamt,
    input  logic [AW-1:0]     cmd_rs,
    input  logic [AW-1:0]     cmd_rt,
    input  logic [AW-1:0]     cmd_rd,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] alu_inA,
    output logic [DATA_W-1:0] alu_inB,
    output logic [1:0]        alu_op,
    output logic [1:0]        alu_inC,
    input  logic [DATA_W-1:0] alu_ans,
    output logic              done_valid,
    output logic [AW-1:0]     done_rd,
    output logic [DATA_W-1:0] done_data
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [7:0]        cmd_count
`endif
);

    seqState           state;
    logic [AW-1:0]     rdQ;
    logic [DATA_W-1:0] resultQ;
    logic [DATA_W-1:0] readA;
    logic [DATA_W-1:0] readB;
    logic              wbWe;

    // Writeback lands on the same edge that raises done_valid.
    assign wbWe = (state == S_WB);

    alu_issue_rf #(
        .NREG   (NREG),
        .DATA_W (DATA_W)
    ) uRf (
        .clk      (clk),
        .reset    (reset),
        .raddrA   (cmd_rs),
        .rdataA   (readA),
        .raddrB   (cmd_rt),
        .rdataB   (readB),
        .wbWe     (wbWe),
        .wbAddr   (rdQ),
        .wbData   (resultQ),
        .hostWe   (host_we),
        .hostAddr (host_addr),
        .hostData (host_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            alu_inA    <= '0;
            alu_inB    <= '0;
            alu_op     <= '0;
            alu_inC    <= '0;
            rdQ        <= '0;
            resultQ    <= '0;
            done_valid <= 1'b0;
            done_rd    <= '0;
            done_data  <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_inA   <= readA;
                        alu_inB   <= readB;
                        alu_op    <= cmd_op;
                        alu_inC   <= cmd_shamt;
                        rdQ       <= cmd_rd;
                        cmd_ready <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resultQ <= alu_ans;
                    state   <= S_WB;
                end
                S_WB: begin
                    done_valid <= 1'b1;
                    done_rd    <= rdQ;
                    done_data  <= resultQ;
                    cmd_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_count <= '0;
        end else if (wbWe && (cmd_count != CNT_MAX)) begin
            cmd_count <= cmd_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural 4-bit ALU attached.
// Build with ALU_ISSUE_CNT_EN defined to also cover the retired-command counter.
module tb_alu_issue_seq;
    import alu_issue_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [1:0] cmdShamt;
    logic [1:0] cmdRs;
    logic [1:0] cmdRt;
    logic [1:0] cmdRd;
    logic       hostWe;
    logic [1:0] hostAddr;
    logic [3:0] hostWdata;
    logic [3:0] aluInA;
    logic [3:0] aluInB;
    logic [1:0] aluOp;
    logic [1:0] aluInC;
    logic [3:0] aluAns;
    logic       doneValid;
    logic [1:0] doneRd;
    logic [3:0] doneData;
`ifdef ALU_ISSUE_CNT_EN
    logic [7:0] cmdCount;
`endif

    int assertCount = 0;
    int failCount   = 0;

    alu_issue_seq #(.NREG(4), .DATA_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_op     (cmdOp),
        .cmd_shamt  (cmdShamt),
        .cmd_rs     (cmdRs),
        .cmd_rt     (cmdRt),
        .cmd_rd     (cmdRd),
        .host_we    (hostWe),
        .host_addr  (hostAddr),
        .host_wdata (hostWdata),
        .alu_inA    (aluInA),
        .alu_inB    (aluInB),
        .alu_op     (aluOp),
        .alu_inC    (aluInC),
        .alu_ans    (aluAns),
        .done_valid (doneValid),
        .done_rd    (doneRd),
        .done_data  (doneData)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .cmd_count  (cmdCount)
`endif
    );

    // The combinational ALU the sequencer drives.
    always_comb begin
        aluAns = '0;
        case (aluOp)
            OP_SRA:  aluAns = 4'($signed(aluInA) >>> aluInC);
            OP_SRL:  aluAns = aluInA >> aluInC;
            OP_SUB:  aluAns = aluInA - aluInB;
            default: aluAns = aluInA + aluInB;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hostWrite(input logic [1:0] addr, input logic [3:0] data);
        hostWe    = 1'b1;
        hostAddr  = addr;
        hostWdata = data;
        tick();
        hostWe    = 1'b0;
    endtask

    // Presents a command and returns just after its accept edge (FSM in EXEC).
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] shamt,
                                 input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
        int waitCycles = 0;
        while (!cmdReady && waitCycles < 10) begin
            tick();
            waitCycles++;
        end
        checkOutput("readyBeforeIssue", cmdReady, 1'b1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdShamt = shamt;
        cmdRs    = rs;
        cmdRt    = rt;
        cmdRd    = rd;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic runCmd(input logic [1:0] op, input logic [1:0] shamt, input logic [1:0] rs,
                          input logic [1:0] rt, input logic [1:0] rd, input logic [3:0] expData,
                          input string tag);
        applyStimulus(op, shamt, rs, rt, rd);
        checkOutput({tag, ".execReady"}, cmdReady, 1'b0);
        checkOutput({tag, ".execDone"}, doneValid, 1'b0);
        tick();
        checkOutput({tag, ".wbReady"}, cmdReady, 1'b0);
        checkOutput({tag, ".wbDone"}, doneValid, 1'b0);
        tick();
        checkOutput({tag, ".doneValid"}, doneValid, 1'b1);
        checkOutput({tag, ".doneData"}, doneData, expData);
        checkOutput({tag, ".doneRd"}, doneRd, rd);
        checkOutput({tag, ".readyAgain"}, cmdReady, 1'b1);
    endtask

    // SRL by 0 with rs=rt=rd reads a register back without changing it.
    task automatic readReg(input logic [1:0] addr, input logic [3:0] expData);
        runCmd(OP_SRL, 2'd0, addr, addr, addr, expData, "readReg");
    endtask

    initial begin
        reset     = 1'b1;
        cmdValid  = 1'b0;
        cmdOp     = '0;
        cmdShamt  = '0;
        cmdRs     = '0;
        cmdRt     = '0;
        cmdRd     = '0;
        hostWe    = 1'b0;
        hostAddr  = '0;
        hostWdata = '0;
        #12;
        checkOutput("rstReady", cmdReady, 1'b1);
        checkOutput("rstDoneValid", doneValid, 1'b0);
        checkOutput("rstDoneRd", doneRd, 2'd0);
        checkOutput("rstDoneData", doneData, 4'h0);
        checkOutput("rstAluInA", aluInA, 4'h0);
        checkOutput("rstAluInB", aluInB, 4'h0);
        checkOutput("rstAluOp", aluOp, 2'd0);
        checkOutput("rstAluInC", aluInC, 2'd0);
        reset = 1'b0;
        tick();

        // Subtract with borrow: 3 - 5 = 0xE.
        hostWrite(2'd0, 4'd3);
        hostWrite(2'd1, 4'd5);
        runCmd(OP_SUB, 2'd0, 2'd0, 2'd1, 2'd2, 4'hE, "sub");
        readReg(2'd2, 4'hE);

        // Addition wraps modulo 16: 9 + 8 = 1.
        hostWrite(2'd0, 4'd9);
        hostWrite(2'd1, 4'd8);
        runCmd(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd3, 4'h1, "addWrap");

        // Shifts on 4'b1000, issued back to back.
        hostWrite(2'd0, 4'b1000);
        runCmd(OP_SRA, 2'd1, 2'd0, 2'd0, 2'd1, 4'hC, "sra1");
        runCmd(OP_SRL, 2'd1, 2'd0, 2'd0, 2'd1, 4'h4, "srl1");
        runCmd(OP_SRA, 2'd3, 2'd0, 2'd0, 2'd1, 4'hF, "sra3");
        // rs==rt==rd: r1 = 0xF + 0xF = 0xE, later command sees it.
        runCmd(OP_ADD, 2'd0, 2'd1, 2'd1, 2'd1, 4'hE, "selfAdd");
        readReg(2'd1, 4'hE);

        // Writeback beats a same-cycle host write to the same register.
        hostWrite(2'd1, 4'd9);
        applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd2);
        tick();
        hostWe = 1'b1; hostAddr = 2'd2; hostWdata = 4'd7;
        tick();
        hostWe = 1'b0;
        checkOutput("wbWinsDone", doneValid, 1'b1);
        checkOutput("wbWinsData", doneData, 4'h1);
        readReg(2'd2, 4'h1);

        // Different addresses in the writeback cycle: both land.
        applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd3);
        tick();
        hostWe = 1'b1; hostAddr = 2'd1; hostWdata = 4'd5;
        tick();
        hostWe = 1'b0;
        checkOutput("bothWbData", doneData, 4'h1);
        readReg(2'd1, 4'h5);
        readReg(2'd3, 4'h1);

        // Host write in the accept cycle is not seen by the operand read.
        hostWe = 1'b1; hostAddr = 2'd0; hostWdata = 4'd6;
        applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd3);
        hostWe = 1'b0;
        checkOutput("oldOperandA", aluInA, 4'h8);
        checkOutput("oldOperandB", aluInB, 4'h5);
        tick();
        tick();
        checkOutput("oldOperandDone", doneData, 4'hD);
        readReg(2'd0, 4'h6);

        // cmd_valid outside IDLE is ignored; done fields hold afterwards.
        applyStimulus(OP_SUB, 2'd0, 2'd0, 2'd1, 2'd2);
        cmdValid = 1'b1; cmdOp = OP_ADD; cmdRd = 2'd3; cmdRs = 2'd3;
        tick();
        tick();
        cmdValid = 1'b0;
        checkOutput("ignoreDoneValid", doneValid, 1'b1);
        checkOutput("ignoreDoneRd", doneRd, 2'd2);
        checkOutput("ignoreDoneData", doneData, 4'h1);
        tick();
        checkOutput("pulseEnds", doneValid, 1'b0);
        checkOutput("holdDoneRd", doneRd, 2'd2);
        checkOutput("holdDoneData", doneData, 4'h1);
        checkOutput("holdAluOp", aluOp, OP_SUB);
        checkOutput("idleReady", cmdReady, 1'b1);

        // Reset during EXEC abandons the command.
        applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd2);
        reset = 1'b1;
        #1;
        checkOutput("midRstReady", cmdReady, 1'b1);
        checkOutput("midRstDone", doneValid, 1'b0);
        tick();
        tick();
        checkOutput("inRstDone", doneValid, 1'b0);
        reset = 1'b0;
        tick();
        checkOutput("postRstDone", doneValid, 1'b0);
        checkOutput("postRstReady", cmdReady, 1'b1);
        for (int r = 0; r < 4; r++) begin
            readReg(2'(r), 4'h0);
        end
        hostWrite(2'd0, 4'd2);
        hostWrite(2'd1, 4'd3);
        runCmd(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd2, 4'h5, "postRstAdd");

`ifdef ALU_ISSUE_CNT_EN
        // Five commands retired since the last reset.
        tick();
        checkOutput("countFive", cmdCount, 8'd5);
        reset = 1'b1;
        #1;
        checkOutput("countRst", cmdCount, 8'd0);
        reset = 1'b0;
        tick();
        hostWrite(2'd0, 4'd1);
        hostWrite(2'd1, 4'd1);
        for (int n = 0; n < 257; n++) begin
            applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd1, 2'd2);
            tick();
            tick();
        end
        tick();
        checkOutput("countSat", cmdCount, 8'd255);
        reset = 1'b1;
        #1;
        checkOutput("countSatRst", cmdCount, 8'd0);
        reset = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
